data_mem_initiator: RTL and testbench

Initiator side of the processor's data-memory stall handshake. It accepts one load/store at a time from the pipeline and drives the address, write data, read/write strobes and 4-bit sign mask to the data memory. It tracks the memory's `clk_stall` rise and fall, captures load data, checks alignment and bounds every access with timeouts. It sits between the execute/memory stage and the data memory.

---
 rtl/data_mem_initiator_pkg.sv | 29 ++
 rtl/lsu_mask_decode.sv | 43 ++++
 rtl/data_mem_initiator.sv | 175 +++++++++++++++++
 tb/tb_data_mem_initiator.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_initiator_pkg.sv
// rtl/data_mem_initiator_pkg.sv - shared types and constants for the data-memory initiator
// Purpose: FSM state encoding, sign-mask size codes, RV32 load/store funct3
//          codes and response error codes used by the initiator and its decoder.
// Ports:   none (package).
package data_mem_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RISE     = 2'b10;
  localparam logic [1:0] ERR_BUSY     = 2'b11;

endpackage

// File: rtl/lsu_mask_decode.sv
// rtl/lsu_mask_decode.sv - funct3/write/addr to memory sign mask and misalignment flag
// Purpose: combinational decode of a load/store into the memory's
//          {signed, size[2:0]} mask and an alignment error flag.
// Ports:
//   funct3     in  3  RV32 load/store funct3
//   write      in  1  1 = store, 0 = load
//   addr_lo    in  2  byte address bits [1:0]
//   sign_mask  out 4  {signed, size}
//   misaligned out 1  access not naturally aligned for its size
module lsu_mask_decode
  import data_mem_initiator_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       write,
  input  logic [1:0] addr_lo,
  output logic [3:0] sign_mask,
  output logic       misaligned
);

  logic [2:0] size;
  logic       is_signed;

  always_comb begin
    size       = MASK_WORD;
    is_signed  = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: size = MASK_BYTE;
      F3_H, F3_HU: size = MASK_HALF;
      default:     size = MASK_WORD;  // W and any unused code
    endcase
    // Stores never sign-extend; only B and H loads do.
    is_signed = !write && ((funct3 == F3_B) || (funct3 == F3_H));
    if (size == MASK_HALF) begin
      misaligned = addr_lo[0];
    end else if (size == MASK_WORD) begin
      misaligned = (addr_lo != 2'b00);
    end
  end

  assign sign_mask = {is_signed, size};

endmodule

// File: rtl/data_mem_initiator.sv
// rtl/data_mem_initiator.sv - initiator side of the data-memory stall handshake
// Purpose: accepts one load/store at a time, drives registered memory
//          address/data/strobes/mask, follows clk_stall rise and fall with
//          timeouts, captures load data and returns a one-cycle response.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write/req_funct3    store flag and RV32 funct3
//   req_addr/req_wdata      byte address and right-aligned store data
//   resp_valid/resp_err     one-cycle completion pulse and error code
//   resp_rdata              load result, held between responses
//   mem_addr/mem_write_data memory address and write data
//   mem_memwrite/memread    memory strobes
//   mem_sign_mask           {signed, size} to the memory
//   mem_read_data           memory read data
//   mem_clk_stall           memory busy flag
module data_mem_initiator
  import data_mem_initiator_pkg::*;
#(
  parameter int RISE_TIMEOUT = 8,
  parameter int BUSY_TIMEOUT = 16
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  // Timeout fires on the last allowed cycle, so the FSM spends exactly
  // RISE_TIMEOUT cycles in ISSUE / BUSY_TIMEOUT cycles in BUSY.
  localparam logic [4:0] RISE_LAST = 5'(RISE_TIMEOUT - 1);
  localparam logic [4:0] BUSY_LAST = 5'(BUSY_TIMEOUT - 1);

  state_t     state, state_next;
  logic [4:0] cnt, cnt_next;
  logic       req_is_write;

  logic [3:0] dec_mask;
  logic       dec_misaligned;

  logic       accept;
  logic       go_resp;
  logic [1:0] err_next;
  logic       capture;

  lsu_mask_decode u_decode (
    .funct3     (req_funct3),
    .write      (req_write),
    .addr_lo    (req_addr[1:0]),
    .sign_mask  (dec_mask),
    .misaligned (dec_misaligned)
  );

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    go_resp    = 1'b0;
    err_next   = ERR_OK;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (dec_misaligned) begin
            state_next = ST_RESP;
            go_resp    = 1'b1;
            err_next   = ERR_MISALIGN;
          end else begin
            state_next = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // A stall already high on entry counts as the rise.
        if (mem_clk_stall) begin
          state_next = ST_BUSY;
        end else if (cnt >= RISE_LAST) begin
          state_next = ST_RESP;
          go_resp    = 1'b1;
          err_next   = ERR_RISE;
        end
      end
      ST_BUSY: begin
        if (!mem_clk_stall) begin
          state_next = ST_RESP;
          go_resp    = 1'b1;
          capture    = !req_is_write;
        end else if (cnt >= BUSY_LAST) begin
          state_next = ST_RESP;
          go_resp    = 1'b1;
          err_next   = ERR_BUSY;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (state_next != state) begin
      cnt_next = 5'd0;
    end else if (cnt != 5'h1f) begin
      cnt_next = cnt + 5'd1;
    end else begin
      cnt_next = cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= 5'd0;
      req_is_write   <= 1'b0;
      resp_valid     <= 1'b0;
      resp_err       <= ERR_OK;
      resp_rdata     <= 32'd0;
      mem_addr       <= 32'd0;
      mem_write_data <= 32'd0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= 4'd0;
    end else begin
      cnt        <= cnt_next;
      resp_valid <= go_resp;
      if (go_resp) begin
        resp_err <= err_next;
      end
      if (capture) begin
        resp_rdata <= mem_read_data;
      end
      if (accept) begin
        req_is_write <= req_write;
      end

      if (accept && !dec_misaligned) begin
        mem_addr       <= req_addr;
        mem_write_data <= req_write ? req_wdata : 32'd0;
        mem_memwrite   <= req_write;
        mem_memread    <= !req_write;
        mem_sign_mask  <= dec_mask;
      end else if (go_resp) begin
        // Strobes drop in RESP so the memory sees an input change between
        // consecutive requests, even identical ones.
        mem_memwrite  <= 1'b0;
        mem_memread   <= 1'b0;
        mem_sign_mask <= 4'd0;
      end else if (state == ST_RESP) begin
        mem_addr       <= 32'd0;
        mem_write_data <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_initiator.sv
// tb/tb_data_mem_initiator.sv - self-checking bench for data_mem_initiator
module tb_data_mem_initiator;

  localparam int RISE_TO = 8;
  localparam int BUSY_TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  data_mem_initiator #(.RISE_TIMEOUT(RISE_TO), .BUSY_TIMEOUT(BUSY_TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          rise_cnt = 0;
  int          mem_mode = 0;   // 0 normal, 1 stall never rises, 2 stall stuck high
  int          stall_len = 2;
  logic [31:0] last_rd = 32'd0;
  logic [7:0]  ref_mem [256];
  logic [7:0]  mem_bytes [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v = 32'd0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(int'(a[7:0]) + i) % 256];
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    else if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // Memory model: reacts to the registered outputs just after each edge.
  // Stall rises one cycle after a new strobe and stays high stall_len cycles.
  initial begin
    logic strobe, prev;
    int   phase, left, sz;
    logic [31:0] v;
    mem_clk_stall = 1'b0;
    mem_read_data = 32'd0;
    prev = 1'b0;
    phase = 0;
    left = 0;
    forever begin
      @(posedge clk);
      #1;
      strobe = mem_memread | mem_memwrite;
      if (reset) begin
        mem_clk_stall = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (strobe && !prev) phase = 1;
          1: begin
            if (mem_mode == 1) phase = 0;
            else begin
              mem_clk_stall = 1'b1;
              left = stall_len;
              phase = 2;
            end
          end
          default: begin
            if (!strobe) begin
              mem_clk_stall = 1'b0;
              phase = 0;
            end else if (mem_mode != 2) begin
              left--;
              if (left == 0) begin
                mem_clk_stall = 1'b0;
                sz = (mem_sign_mask[2:0] == 3'b001) ? 1 : (mem_sign_mask[2:0] == 3'b011) ? 2 : 4;
                if (mem_memread) begin
                  v = 32'd0;
                  for (int i = 0; i < sz; i++) v[8*i +: 8] = mem_bytes[(int'(mem_addr[7:0]) + i) % 256];
                  if (mem_sign_mask[3] && sz == 1) v = {{24{v[7]}}, v[7:0]};
                  if (mem_sign_mask[3] && sz == 2) v = {{16{v[15]}}, v[15:0]};
                  mem_read_data = v;
                end else begin
                  for (int i = 0; i < sz; i++) mem_bytes[(int'(mem_addr[7:0]) + i) % 256] = mem_write_data[8*i +: 8];
                end
                phase = 0;
              end
            end
          end
        endcase
      end
      prev = strobe;
    end
  end

  initial begin
    logic s, sp;
    sp = 1'b0;
    forever begin
      @(negedge clk);
      s = mem_memread | mem_memwrite;
      if (s && !sp) rise_cnt++;
      sp = s;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, req_ready, 1);
    chk({tag, "_rvalid"}, resp_valid, 0);
    chk({tag, "_rerr"}, resp_err, 0);
    chk({tag, "_rdata"}, resp_rdata, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_write_data, 0);
    chk({tag, "_strobes"}, {mem_memwrite, mem_memread}, 0);
    chk({tag, "_mask"}, mem_sign_mask, 0);
  endtask

  task automatic do_req(input string tag, input logic [2:0] f3, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int          sz, lat, e_lat;
    logic        mis, got, seen;
    logic [1:0]  e_err;
    logic [31:0] e_rd;
    logic [3:0]  e_mask;
    sz = size_of(f3);
    mis = (a % sz) != 0;
    e_mask = {(!wr && (f3 == 3'd0 || f3 == 3'd1)), (sz == 1) ? 3'b001 : (sz == 2) ? 3'b011 : 3'b111};
    e_rd = last_rd;
    if (mis) begin
      e_err = 2'b01; e_lat = 1;
    end else if (mem_mode == 1) begin
      e_err = 2'b10; e_lat = RISE_TO + 1;
    end else if (mem_mode == 2) begin
      e_err = 2'b11; e_lat = 2 + BUSY_TO + 1;
    end else begin
      e_err = 2'b00; e_lat = 3 + stall_len;
      if (!wr) e_rd = ref_load(f3, a);
    end

    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_funct3 = f3; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_write = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    if (!mis) begin
      chk({tag, "_memwrite"}, mem_memwrite, wr);
      chk({tag, "_memread"}, mem_memread, !wr);
      chk({tag, "_mask"}, mem_sign_mask, e_mask);
      chk({tag, "_addr"}, mem_addr, a);
      if (wr) chk({tag, "_wdata"}, mem_write_data, wd);
    end
    lat = 1;
    got = resp_valid;
    seen = mem_memread | mem_memwrite;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      seen |= mem_memread | mem_memwrite;
      got = resp_valid;
    end
    chk({tag, "_resp_seen"}, got, 1);
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_err"}, resp_err, e_err);
    chk({tag, "_rdata"}, resp_rdata, e_rd);
    if (mis) chk({tag, "_no_strobe"}, seen, 0);
    @(negedge clk);
    chk({tag, "_pulse_end"}, resp_valid, 0);
    chk({tag, "_idle_again"}, req_ready, 1);

    if (!mis && mem_mode == 0 && wr)
      for (int i = 0; i < sz; i++) ref_mem[(int'(a[7:0]) + i) % 256] = wd[8*i +: 8];
    last_rd = e_rd;
  endtask

  initial begin
    int   r0;
    logic got;
    logic [7:0] b;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      ref_mem[i] = b; mem_bytes[i] = b;
    end
    ref_mem[8'h08] = 8'hEF; ref_mem[8'h09] = 8'hBE; ref_mem[8'h0A] = 8'hAD; ref_mem[8'h0B] = 8'hDE;
    ref_mem[8'h03] = 8'h85;
    mem_bytes[8'h08] = 8'hEF; mem_bytes[8'h09] = 8'hBE; mem_bytes[8'h0A] = 8'hAD; mem_bytes[8'h0B] = 8'hDE;
    mem_bytes[8'h03] = 8'h85;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    mem_mode = 0; stall_len = 2;
    do_req("lw", 3'd2, 1'b0, 32'h1008, 32'd0);
    chk("lw_value", resp_rdata, 32'hDEADBEEF);
    do_req("lb", 3'd0, 1'b0, 32'h1003, 32'd0);
    chk("lb_value", resp_rdata, 32'hFFFFFF85);

    r0 = rise_cnt;
    do_req("sh1", 3'd1, 1'b1, 32'h1002, 32'h0000ABCD);
    do_req("sh2", 3'd1, 1'b1, 32'h1002, 32'h0000ABCD);
    chk("sh_strobe_gap", rise_cnt - r0, 2);
    do_req("lhu_after_sh", 3'd5, 1'b0, 32'h1002, 32'd0);

    do_req("misalign_lw", 3'd2, 1'b0, 32'h1001, 32'd0);

    mem_mode = 1;
    do_req("rise_to", 3'd2, 1'b0, 32'h1010, 32'd0);
    mem_mode = 2;
    do_req("busy_to", 3'd2, 1'b0, 32'h1014, 32'd0);
    mem_mode = 0;
    repeat (2) @(negedge clk);

    stall_len = 6;
    req_valid = 1'b1; req_funct3 = 3'd2; req_write = 1'b0; req_addr = 32'h1008; req_wdata = 32'd0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_busy");
    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      got |= resp_valid;
    end
    chk("rst_no_resp", got, 0);
    last_rd = 32'd0;
    stall_len = 2;
    do_req("lw_after_rst", 3'd2, 1'b0, 32'h1008, 32'd0);

    for (int n = 0; n < 40; n++) begin
      stall_len = $urandom_range(1, 4);
      do_req("rand", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             32'h1000 + $urandom_range(0, 255), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
